// File: rtl/mdu_hilo_if.sv
// ---------------------------------------------------------------------------
// mdu_hilo_if
// Request/result bundle between the execute stage and the multiply/divide
// unit.
//   start : one-cycle request strobe
//   op    : 4-bit operation code (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU)
//   a, b  : rs / rt operands
//   busy  : a multi-cycle operation is in flight
//   hi,lo : architectural HI / LO registers
// master = execute stage (drives requests), slave = the MDU itself.
// ---------------------------------------------------------------------------
interface mdu_hilo_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_hilo.sv
// ---------------------------------------------------------------------------
// mdu_hilo
// Multiply/divide unit with HI/LO registers for the execute stage.
// Multi-cycle ops are computed at acceptance into a pending register and
// committed to HI/LO when the fixed-latency countdown finishes.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : mdu_hilo_if.slave (start/op/a/b in, busy/hi/lo out)
// Parameters:
//   MUL_CYCLES : busy cycles for MULT/MULTU/MADD/MADDU (>= 1)
//   DIV_CYCLES : busy cycles for DIV/DIVU (>= 1)
// Configuration macro:
//   MDU_MADD_EN : when defined, ops 7 (MADD) and 8 (MADDU) accumulate into
//                 HI:LO; when undefined they are no-ops.
// ---------------------------------------------------------------------------
module mdu_hilo #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_hilo_if.slave  bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             busy_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [63:0]      pend;
    logic             pend_wr;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               div_ovf;
    logic               long_op;
    logic               is_div;
    logic               res_wr;
    logic        [63:0] res;

    assign bus.busy = busy_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    assign prod_s  = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    assign prod_u  = {32'h0, bus.a} * {32'h0, bus.b};
    assign div_ovf = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);

    // Dividers are guarded so a zero divisor or the one signed overflow case
    // never reaches the '/' operator; the overflow case has a fixed answer
    // (quotient wraps to 0x80000000, remainder 0).
    always_comb begin
        quo_s = '0;
        rem_s = '0;
        quo_u = '0;
        rem_u = '0;
        if (bus.b != 32'h0) begin
            quo_u = bus.a / bus.b;
            rem_u = bus.a % bus.b;
            if (div_ovf) begin
                quo_s = 32'sh8000_0000;
            end else begin
                quo_s = $signed(bus.a) / $signed(bus.b);
                rem_s = $signed(bus.a) % $signed(bus.b);
            end
        end
    end

    // Decode the requested op into "does it start a countdown", which latency
    // it uses, and the 64-bit HI:LO value it will commit. A divide by zero
    // still runs but commits nothing. MADD accumulates on the current HI:LO,
    // which cannot change while the op is in flight.
    always_comb begin
        long_op = 1'b0;
        is_div  = 1'b0;
        res_wr  = 1'b1;
        res     = '0;
        case (bus.op)
            OP_MULT: begin
                long_op = 1'b1;
                res     = prod_s;
            end
            OP_MULTU: begin
                long_op = 1'b1;
                res     = prod_u;
            end
            OP_DIV: begin
                long_op = 1'b1;
                is_div  = 1'b1;
                res_wr  = (bus.b != 32'h0);
                res     = {rem_s, quo_s};
            end
            OP_DIVU: begin
                long_op = 1'b1;
                is_div  = 1'b1;
                res_wr  = (bus.b != 32'h0);
                res     = {rem_u, quo_u};
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                long_op = 1'b1;
                res     = {hi_r, lo_r} + prod_s;
            end
            OP_MADDU: begin
                long_op = 1'b1;
                res     = {hi_r, lo_r} + prod_u;
            end
`endif
            default: begin
                long_op = 1'b0;
            end
        endcase
    end

    // IDLE/RUN control. In IDLE a long op latches its result and loads the
    // countdown with latency-1; MTHI/MTLO write directly. In RUN every request
    // is ignored and the pending result is committed on the edge where the
    // counter is already zero, which makes busy high for exactly N cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            busy_r  <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            pend    <= '0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (long_op) begin
                            state   <= RUN;
                            busy_r  <= 1'b1;
                            count   <= is_div ? DIV_LOAD : MUL_LOAD;
                            pend    <= res;
                            pend_wr <= res_wr;
                        end else if (bus.op == OP_MTHI) begin
                            hi_r <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            lo_r <= bus.a;
                        end
                    end
                end
                RUN: begin
                    if (count == '0) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        if (pend_wr) begin
                            hi_r <= pend[63:32];
                            lo_r <= pend[31:0];
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// ---------------------------------------------------------------------------
// tb_mdu_hilo
// Self-checking bench for mdu_hilo. A behavioural model (remaining-cycle
// count plus 64-bit integer arithmetic) predicts busy/hi/lo every cycle;
// directed cases cover the known corner values, then randomized requests
// (including requests while busy and odd opcodes) run against the model.
// Honours MDU_MADD_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mdu_hilo;
    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mdu_hilo_if bus ();

    mdu_hilo #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: architectural HI/LO, cycles of busy left, and
    // the value (if any) to commit when the count runs out.
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    int          m_left = 0;
    logic [63:0] m_pend = '0;
    logic        m_wr   = 1'b0;

    // Result of a long op from plain integer arithmetic; bit 64 says whether
    // HI:LO gets written at completion.
    function automatic logic [64:0] modelResult(input logic [3:0] op,
                                                input logic [31:0] a,
                                                input logic [31:0] b,
                                                input logic [63:0] acc);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            4'd1: return {1'b1, 64'(sa * sb)};
            4'd2: return {1'b1, 64'(ua * ub)};
            4'd3: begin
                if (b == 32'h0) return {1'b0, acc};
                q = sa / sb;
                r = sa % sb;
                return {1'b1, r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'h0) return {1'b0, acc};
                uq = ua / ub;
                ur = ua % ub;
                return {1'b1, ur[31:0], uq[31:0]};
            end
            4'd7: return {1'b1, 64'(acc + 64'(sa * sb))};
            4'd8: return {1'b1, 64'(acc + 64'(ua * ub))};
            default: return {1'b0, acc};
        endcase
    endfunction

    function automatic int modelLatency(input logic [3:0] op);
        case (op)
            4'd1, 4'd2: return MUL_N;
            4'd3, 4'd4: return DIV_N;
`ifdef MDU_MADD_EN
            4'd7, 4'd8: return MUL_N;
`endif
            default: return 0;
        endcase
    endfunction

    // Model update on every rising edge, cleared by reset without a clock.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
            m_wr   <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_wr) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
        end else if (bus.start) begin
            if (modelLatency(bus.op) != 0) begin
                m_left          <= modelLatency(bus.op);
                {m_wr, m_pend}  <= modelResult(bus.op, bus.a, bus.b, {m_hi, m_lo});
            end else if (bus.op == 4'd5) begin
                m_hi <= bus.a;
            end else if (bus.op == 4'd6) begin
                m_lo <= bus.a;
            end
        end
    end

    // The single comparison point: counts the check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Every falling edge, the DUT outputs must match the model.
    always @(negedge clk) begin
        checkOutput("model_busy", 64'(bus.busy), 64'(m_left != 0));
        checkOutput("model_hi", 64'(bus.hi), 64'(m_hi));
        checkOutput("model_lo", 64'(bus.lo), 64'(m_lo));
    end

    // Issue one request for one cycle; called and returns at a falling edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 4'd0;
    endtask

    // Count falling edges with busy high, bounded so a stuck busy fails.
    task automatic waitIdle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    int n;

    initial begin
        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'h0);
        checkOutput("reset_hi", 64'(bus.hi), 64'h0);
        checkOutput("reset_lo", 64'(bus.lo), 64'h0);
        reset = 1'b1;
        @(negedge clk);

        // Signed multiply -2 * 3.
        applyStimulus(4'd1, 32'hFFFF_FFFE, 32'd3);
        waitIdle(n);
        checkOutput("mult_busy_len", 64'(n), 64'(MUL_N));
        checkOutput("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        checkOutput("mult_lo", 64'(bus.lo), 64'hFFFF_FFFA);

        // Unsigned multiply, issued in the first cycle after busy fell.
        applyStimulus(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("b2b_accept", 64'(bus.busy), 64'h1);
        waitIdle(n);
        checkOutput("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        checkOutput("multu_lo", 64'(bus.lo), 64'h0000_0001);

        // Signed divide -7 / 2.
        applyStimulus(4'd3, 32'hFFFF_FFF9, 32'd2);
        waitIdle(n);
        checkOutput("div_busy_len", 64'(n), 64'(DIV_N));
        checkOutput("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        checkOutput("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);

        // Divide by zero: full latency, HI/LO untouched.
        applyStimulus(4'd4, 32'd7, 32'd0);
        waitIdle(n);
        checkOutput("div0_busy_len", 64'(n), 64'(DIV_N));
        checkOutput("div0_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        checkOutput("div0_lo", 64'(bus.lo), 64'hFFFF_FFFD);

        // Signed overflow divide.
        applyStimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle(n);
        checkOutput("divovf_hi", 64'(bus.hi), 64'h0);
        checkOutput("divovf_lo", 64'(bus.lo), 64'h8000_0000);

        // MTLO in IDLE: visible next cycle, no busy.
        applyStimulus(4'd6, 32'h0000_1234, 32'd0);
        checkOutput("mtlo_lo", 64'(bus.lo), 64'h1234);
        checkOutput("mtlo_busy", 64'(bus.busy), 64'h0);

        // MTHI while a multiply is running is dropped.
        applyStimulus(4'd1, 32'd2, 32'd3);
        applyStimulus(4'd5, 32'h0000_DEAD, 32'd0);
        waitIdle(n);
        checkOutput("mthi_run_hi", 64'(bus.hi), 64'h0);
        checkOutput("mthi_run_lo", 64'(bus.lo), 64'h6);

        // Unused opcode does nothing.
        applyStimulus(4'd12, 32'h5555_5555, 32'h1);
        checkOutput("nop_busy", 64'(bus.busy), 64'h0);
        checkOutput("nop_lo", 64'(bus.lo), 64'h6);

        // MADD 1*1 onto 0:0xFFFFFFFF.
        applyStimulus(4'd5, 32'h0, 32'd0);
        applyStimulus(4'd6, 32'hFFFF_FFFF, 32'd0);
        applyStimulus(4'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        checkOutput("madd_busy", 64'(bus.busy), 64'h1);
        waitIdle(n);
        checkOutput("madd_hi", 64'(bus.hi), 64'h1);
        checkOutput("madd_lo", 64'(bus.lo), 64'h0);
`else
        checkOutput("madd_off_busy", 64'(bus.busy), 64'h0);
        checkOutput("madd_off_hi", 64'(bus.hi), 64'h0);
        checkOutput("madd_off_lo", 64'(bus.lo), 64'hFFFF_FFFF);
`endif

        // Reset in the middle of a divide, between clock edges.
        applyStimulus(4'd3, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 64'(bus.busy), 64'h0);
        checkOutput("rst_mid_hi", 64'(bus.hi), 64'h0);
        checkOutput("rst_mid_lo", 64'(bus.lo), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(4'd2, 32'd9, 32'd9);
        checkOutput("post_rst_accept", 64'(bus.busy), 64'h1);
        waitIdle(n);
        checkOutput("post_rst_lo", 64'(bus.lo), 64'd81);

        // Random traffic, including requests while busy and unused opcodes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.start = 1'b1;
                bus.op    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                        : 4'($urandom_range(1, 8));
                bus.a     = pickOperand();
                bus.b     = pickOperand();
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        waitIdle(n);
        checkOutput("final_idle", 64'(bus.busy), 64'h0);

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multiply/divide unit with HI/LO registers for the MIPS pipeline's execute stage. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO requests from E, computes them over a fixed multi-cycle latency, and holds the 64-bit result in HI/LO. MFHI/MFLO in E read it combinationally. While `busy` is asserted, the hazard unit stalls any MDU instruction sitting in D.

## Interface
- `MUL_CYCLES`, default 5: cycles `busy` stays high for MULT/MULTU/MADD/MADDU. Must be at least 1.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for DIV/DIVU. Must be at least 1.
- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: asynchronous, active-low.
- `start`  in  1: request strobe, valid for one cycle.
- `op`  in  4: operation code.
  - 0: none
  - 1: MULT
  - 2: MULTU
  - 3: DIV
  - 4: DIVU
  - 5: MTHI
  - 6: MTLO
  - 7: MADD
  - 8: MADDU
  - 9–15: none
- `a`  in  32: rs operand.
- `b`  in  32: rt operand.
- `busy`  out  1: a multi-cycle operation is in flight.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.

## Operation
- **Reset (`reset`=0).** Takes effect immediately, independent of `clk`.
  - `hi`=0, `lo`=0, `busy`=0, cycle counter=0.
  - Any in-flight result is discarded.
- **States: IDLE and RUN.**
  - IDLE → RUN on `start`=1 with op in {1,2,3,4}, or {7,8} if enabled.
  - In RUN the counter loads the latency minus 1 and decrements each cycle.
  - RUN → IDLE when the counter is 0. On that same edge the pending result is written to HI/LO.
- **Result computation.** Operands and op are latched at the accepting edge. The result may be computed then and held in a pending register.
- **MULT / MULTU.** HI:LO = a×b, 64-bit, signed or unsigned.
- **DIV / DIVU.**
  - LO = quotient, truncated toward zero.
  - HI = remainder, taking the sign of the dividend `a`.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero: the full DIV_CYCLES latency still runs; HI/LO are left unchanged at completion.
- **MTHI / MTLO.** In IDLE with `start`=1, `a` is written to HI or LO at that edge. `busy` does not assert.
- **`start` during RUN.** Ignored. No queueing, no effect on the operation in flight. The pipeline must stall instead.
- **`start` with op 0 or 9–15.** No effect.
- **Output visibility.** `hi`/`lo` change only at completion, on an MTHI/MTLO write, or on reset. MFHI/MFLO issued during RUN therefore read the old values; the stall logic prevents this.

## Timing
- Latency, with `start` sampled at edge T0:
  - `busy` is 1 after T0.
  - Result visible and `busy` 0 after edge T0+N, where N is MUL_CYCLES or DIV_CYCLES.
  - `busy` is high for exactly N cycles.
- **Back-to-back.** A new `start` in the first cycle after `busy` falls is accepted. Throughput is one operation per N+1 cycles at most when issued from the earliest legal slot.
- **MTHI/MTLO.** Result visible one edge after `start`.
- **Reset mid-RUN.** `busy` drops asynchronously and HI/LO clear. The first `start` after `reset` returns high is accepted normally.
- **Combinational paths.** `busy`, `hi` and `lo` come directly from registers; there are no combinational paths from inputs to outputs.

## Configuration
- **`MDU_MADD_EN` defined.**
  - Op 7 (MADD): HI:LO = HI:LO + signed(a×b), mod 2^64.
  - Op 8 (MADDU): HI:LO = HI:LO + unsigned(a×b), mod 2^64.
  - Both have MUL_CYCLES latency.
  - The accumulate uses the HI:LO value at completion, which equals the value at acceptance since HI/LO cannot change during RUN.
- **`MDU_MADD_EN` undefined.** Ops 7 and 8 are treated as no-ops: IDLE is held and `busy` stays 0.

## Test plan
- **Signed multiply.** Reset, then `start` MULT a=0xFFFFFFFE (−2), b=3 → `busy` high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- **Unsigned multiply.** MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- **Signed divide.** DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **Divide by zero.** DIVU a=7, b=0 → `busy` 10 cycles, hi/lo unchanged.
- **Busy handling and MT writes.**
  - MTLO a=0x1234 while IDLE → lo=0x1234 next cycle, `busy`=0.
  - MTHI issued during RUN → ignored.
  - `start` in the first cycle after `busy` falls → accepted.
- **Reset mid-operation.** Pull `reset` low at cycle 3 of a DIV → `busy`=0, hi=lo=0 immediately, with no clock edge required.
- **MADD (with `MDU_MADD_EN`).** hi:lo=0:0xFFFFFFFF, then MADD a=1, b=1 → hi=1, lo=0.
